// File: rtl/ovf_ctrl_pkg.sv
// ============================================================================
// Module   : ovf_ctrl_pkg
// Brief    : Shared types and helpers for the overflow-interval controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ovf_ctrl_pkg;

  localparam int ADDR_W = 32;
  localparam int ID_W   = 3;

  typedef enum logic [1:0] {
    ST_WRITTEN   = 2'b00,
    ST_DUPLICATE = 2'b01,
    ST_INVALID   = 2'b10
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  // first == last is a legal one-byte interval
  function automatic logic interval_ok(input logic [ADDR_W-1:0] first,
                                       input logic [ADDR_W-1:0] last);
    return (first <= last);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ovf_rr_arbiter.sv
// ============================================================================
// Module   : ovf_rr_arbiter
// Brief    : Combinational round-robin pick, first request strictly after ptr.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ovf_rr_arbiter
  import ovf_ctrl_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [ID_W-1:0] ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] grant_o,
  output logic [ID_W-1:0] grant_idx_o,
  output logic            grant_valid_o
);

  // Two passes: indices above the pointer first, then wrap to the low ones.
  always_comb begin
    grant_o       = '0;
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    if (en_i) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!grant_valid_o && req_i[j] && (j > int'(ptr_i))) begin
          grant_valid_o = 1'b1;
          grant_o[j]    = 1'b1;
          grant_idx_o   = ID_W'(j);
        end
      end
      for (int j = 0; j < NREQ; j++) begin
        if (!grant_valid_o && req_i[j] && (j <= int'(ptr_i))) begin
          grant_valid_o = 1'b1;
          grant_o[j]    = 1'b1;
          grant_idx_o   = ID_W'(j);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ovf_interval_ctrl.sv
// ============================================================================
// Module   : ovf_interval_ctrl
// Brief    : Arbitrates, validates and writes intervals into the overflow
//            buffer; duplicate check enabled by OVF_CTRL_DUPCHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ovf_interval_ctrl
  import ovf_ctrl_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NREQ-1:0]        req_valid_i,
  output logic [NREQ-1:0]        req_ready_o,
  input  logic [NREQ*ADDR_W-1:0] req_first_i,
  input  logic [NREQ*ADDR_W-1:0] req_last_i,
  output logic                   resp_valid_o,
  output logic [ID_W-1:0]        resp_id_o,
  output logic [1:0]             resp_status_o,
  input  logic                   lookup_valid_i,
  input  logic [ADDR_W-1:0]      lookup_addr_i,
  output logic                   lookup_in_range_o,
  output logic                   lookup_is_first_o,
  output logic                   buf_en_write_o,
  output logic [ADDR_W-1:0]      buf_addr_first_o,
  output logic [ADDR_W-1:0]      buf_addr_last_o,
  output logic [ADDR_W-1:0]      buf_current_addr_o,
  input  logic                   buf_addr_in_range_i,
  input  logic                   buf_addr_is_first_i,
  output logic [CNT_W-1:0]       wr_count_o
);

  state_e              state_q, state_d;
  status_e             status_q, status_d;
  logic [ID_W-1:0]     rr_q, rr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ADDR_W-1:0]   first_q, first_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [NREQ-1:0]     grant;
  logic [ID_W-1:0]     grant_idx;
  logic                grant_valid;
  logic [ADDR_W-1:0]   sel_first;
  logic [ADDR_W-1:0]   sel_last;

  // Grants are suppressed while reset is high so no request is consumed
  // by a cycle whose latch will be discarded.
  ovf_rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req_i         (req_valid_i),
    .ptr_i         (rr_q),
    .en_i          ((state_q == S_IDLE) && !rst_i),
    .grant_o       (grant),
    .grant_idx_o   (grant_idx),
    .grant_valid_o (grant_valid)
  );

  always_comb begin
    sel_first = '0;
    sel_last  = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (grant[j]) begin
        sel_first = req_first_i[j*ADDR_W +: ADDR_W];
        sel_last  = req_last_i[j*ADDR_W +: ADDR_W];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      status_q <= ST_WRITTEN;
      rr_q     <= '0;
      id_q     <= '0;
      first_q  <= '0;
      last_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      rr_q     <= rr_d;
      id_q     <= id_d;
      first_q  <= first_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    status_d       = status_q;
    rr_d           = rr_q;
    id_d           = id_q;
    first_d        = first_q;
    last_d         = last_q;
    cnt_d          = cnt_q;
    buf_en_write_o = 1'b0;
    resp_valid_o   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_valid) begin
          rr_d    = grant_idx;
          id_d    = grant_idx;
          first_d = sel_first;
          last_d  = sel_last;
          if (!interval_ok(sel_first, sel_last)) begin
            status_d = ST_INVALID;
            state_d  = S_RESP;
          end else begin
`ifdef OVF_CTRL_DUPCHECK_EN
            state_d = S_CHECK;
`else
            state_d = S_WRITE;
`endif
          end
        end
      end
      S_CHECK: begin
        // The lookup path owns the compare port whenever it is active.
        if (!lookup_valid_i) begin
          if (buf_addr_is_first_i) begin
            status_d = ST_DUPLICATE;
            state_d  = S_RESP;
          end else begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        buf_en_write_o = 1'b1;
        status_d       = ST_WRITTEN;
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        resp_valid_o = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready_o       = grant;
  assign resp_id_o         = id_q;
  assign resp_status_o     = status_q;
  assign buf_addr_first_o  = first_q;
  assign buf_addr_last_o   = last_q;
  assign wr_count_o        = cnt_q;
  assign lookup_in_range_o = buf_addr_in_range_i;
  assign lookup_is_first_o = buf_addr_is_first_i;

`ifdef OVF_CTRL_DUPCHECK_EN
  assign buf_current_addr_o = lookup_valid_i ? lookup_addr_i : first_q;
`else
  assign buf_current_addr_o = lookup_addr_i;
`endif

endmodule

`default_nettype wire

// File: doc/ovf_interval_ctrl.md
Name: ovf_interval_ctrl

Overview:
Sequencer and arbiter in front of the overflow-interval circular buffer.
- Accepts interval-registration requests from NREQ requesters, arbitrated round-robin.
- Validates each interval, optionally suppresses duplicates, then pulses the buffer write.
- Shares the buffer's single compare port (current address) between the load/store lookup path and its own duplicate check.
- Lookup path always has priority on that port.

Parameters:
NREQ, 2, number of registration requesters (1..8)
CNT_W, 16, width of saturating write counter

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
req_valid_i  in  NREQ  request pending, one bit per requester
req_ready_o  out  NREQ  one-hot accept pulse; request is taken in the cycle valid&ready
req_first_i  in  NREQ*32  first address; requester k at bits [32k+31:32k]
req_last_i  in  NREQ*32  last address; same packing
resp_valid_o  out  1  one-cycle completion pulse
resp_id_o  out  3  index of the requester being answered
resp_status_o  out  2  00 WRITTEN, 01 DUPLICATE, 10 INVALID
lookup_valid_i  in  1  load/store checker driving a lookup this cycle
lookup_addr_i  in  32  address to check
lookup_in_range_o  out  1  buffer in-range result, combinational pass-through
lookup_is_first_o  out  1  buffer is-first result, combinational pass-through
buf_en_write_o  out  1  buffer write enable
buf_addr_first_o  out  32  buffer write data, first address
buf_addr_last_o  out  32  buffer write data, last address
buf_current_addr_o  out  32  buffer compare address
buf_addr_in_range_i  in  1  from buffer
buf_addr_is_first_i  in  1  from buffer
wr_count_o  out  CNT_W  number of intervals written, saturating

Behaviour:
Reset (rst_i sampled high at a clock edge):
- State IDLE, rr pointer = 0, latched first/last/id = 0, wr_count_o = 0.
- All outputs driven by the controller are 0.
- Reset mid-operation abandons the latched request: no resp, no write.
- The buffer has its own reset, driven by the top level.

Compare-port mux:
- buf_current_addr_o = lookup_addr_i when lookup_valid_i, else latched first.
- lookup_*_o = buf_*_i at all times.

FSM states IDLE, CHECK, WRITE, RESP:
- IDLE: if any req_valid_i, grant = first set bit at or after (rr pointer + 1) mod NREQ. Assert req_ready_o[grant] for that cycle. Latch first, last and id. Set rr pointer = grant.
  - first > last (unsigned): status INVALID, go to RESP.
  - Otherwise go to CHECK.
  - No request: stay in IDLE, req_ready_o = 0.
- CHECK: if lookup_valid_i, stall in CHECK (port taken; no timeout). Otherwise sample buf_addr_is_first_i against the latched first.
  - 1: status DUPLICATE, go to RESP.
  - 0: go to WRITE.
- WRITE: buf_en_write_o = 1 for exactly one cycle, with buf_addr_first_o/buf_addr_last_o = latched values. Status WRITTEN. Increment wr_count_o, saturating at all-ones. Go to RESP.
- RESP: resp_valid_o = 1 for one cycle with latched id and status. No backpressure. Go to IDLE.
  - A new grant is possible the next cycle, so at most one request is in flight.

Other rules:
- buf_addr_first_o/buf_addr_last_o hold latched values outside WRITE; only buf_en_write_o qualifies them.
- Best-case latency from accept edge: CHECK +1, WRITE +2, resp_valid_o +3 cycles.
- first == last is a valid one-byte interval.
- Requesters must hold valid and data stable until ready.

Optional Feature:
OVF_CTRL_DUPCHECK_EN
- Defined: CHECK state present as above.
- Undefined: IDLE goes directly to WRITE for valid intervals, and status DUPLICATE is never produced. buf_current_addr_o = lookup_addr_i constantly. Latency to resp_valid_o is +2 cycles.

Decomposition:
- Package ovf_ctrl_pkg: ADDR_W = 32; status_e {ST_WRITTEN = 2'b00, ST_DUPLICATE = 2'b01, ST_INVALID = 2'b10}; state_e {S_IDLE, S_CHECK, S_WRITE, S_RESP}.
- Sub-module ovf_rr_arbiter (parameter NREQ): inputs req vector, pointer, enable; output one-hot grant and grant index. Purely combinational; the pointer register stays in the controller.

Test Plan:
- Req0 valid with 0x1000/0x10FF, buffer is_first = 0, no lookup -> ready[0] at cycle 0; en_write at cycle 2 with 0x1000/0x10FF; resp at cycle 3 with id 0, status 00; wr_count = 1.
- Req1 with first 0x2000, last 0x1FFF -> ready[1]; no en_write; resp at cycle 1 with id 1, status 10.
- Both requesters valid continuously for 6 requests after reset -> grants alternate 1,0,1,0,1,0; each resp id matches its grant.
- Request in CHECK while lookup_valid_i = 1 for 3 cycles with addr 0x3000 -> buf_current_addr_o = 0x3000 during the stall; CHECK held 3 extra cycles; write at stall end + 1. Duplicate variant: is_first = 1 -> status 01, no write.
- rst_i asserted in the WRITE-1 (CHECK) cycle -> no en_write and no resp; all outputs 0 next cycle; rr pointer 0, so the first grant after reset goes to requester 1 when both are valid.
- Preload wr_count near max (CNT_W = 2): 4 writes -> count 1,2,3,3 (saturates).
